// File: rtl/riscv_lsu.sv
// Load/store unit between the core datapath and data memory: request/ready handshake with stall,
// byte-lane steering, sign/zero extension, misalignment/illegal-size detection and bus timeout.
module riscv_lsu #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [XLEN-1:0]   core_wd_i,
    output logic              core_stall_o,
    output logic [XLEN-1:0]   core_rd_o,
    output logic              core_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wd_o,
    input  logic [XLEN-1:0]   mem_rd_i,
    input  logic              mem_ready_i
);

    localparam int unsigned BeW  = XLEN / 8;
    localparam int unsigned OffW = $clog2(BeW);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax =
        CntW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [2:0]          size_q, size_d;
    logic [BeW-1:0]      be_q, be_d;
    logic [XLEN-1:0]     wd_q, wd_d;
    logic [OffW-1:0]     off_q, off_d;
    logic                err_q, err_d;
    logic [XLEN-1:0]     rd_q, rd_d;
    logic [CntW-1:0]     cnt_q, cnt_d;

    logic [OffW-1:0]     req_off;
    logic                illegal_size;
    logic                misaligned;
    logic [BeW-1:0]      req_mask;
    logic [XLEN-1:0]     req_wd;
    logic [XLEN-1:0]     rd_shift;
    logic [XLEN-1:0]     load_ext;

    assign req_off = core_addr_i[OffW-1:0];

    // Request decode: legality, lane mask and replicated store data.
    always_comb begin
        illegal_size = (core_size_i == 3'd7) || (core_we_i && core_size_i[2]) ||
                       ((XLEN == 32) && ((core_size_i == 3'd3) || (core_size_i == 3'd6)));
        misaligned = 1'b0;
        req_mask   = '0;
        req_wd     = core_wd_i;
        unique case (core_size_i[1:0])
            2'd0: begin
                misaligned = 1'b0;
                req_mask   = BeW'(8'h01);
                req_wd     = {BeW{core_wd_i[7:0]}};
            end
            2'd1: begin
                misaligned = core_addr_i[0];
                req_mask   = BeW'(8'h03);
                req_wd     = {(XLEN / 16){core_wd_i[15:0]}};
            end
            2'd2: begin
                misaligned = |core_addr_i[1:0];
                req_mask   = BeW'(8'h0F);
                req_wd     = {(XLEN / 32){core_wd_i[31:0]}};
            end
            default: begin
                misaligned = |core_addr_i[2:0];
                req_mask   = BeW'(8'hFF);
                req_wd     = core_wd_i;
            end
        endcase
    end

    assign rd_shift = mem_rd_i >> {off_q, 3'b000};

    always_comb begin
        unique case (size_q)
            3'd0:    load_ext = XLEN'($signed(rd_shift[7:0]));
            3'd1:    load_ext = XLEN'($signed(rd_shift[15:0]));
            3'd2:    load_ext = XLEN'($signed(rd_shift[31:0]));
            3'd4:    load_ext = XLEN'(rd_shift[7:0]);
            3'd5:    load_ext = XLEN'(rd_shift[15:0]);
            3'd6:    load_ext = XLEN'(rd_shift[31:0]);
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        be_d    = be_q;
        wd_d    = wd_q;
        off_d   = off_q;
        err_d   = err_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (core_req_i) begin
                    if (illegal_size || misaligned) begin
                        err_d   = 1'b1;
                        rd_d    = '0;
                        state_d = StDone;
                    end else begin
                        addr_d  = {core_addr_i[ADDR_W-1:OffW], OffW'(0)};
                        we_d    = core_we_i;
                        size_d  = core_size_i;
                        be_d    = req_mask << req_off;
                        wd_d    = req_wd;
                        off_d   = req_off;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (mem_ready_i) begin
                    rd_d    = we_q ? '0 : load_ext;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntMax)) begin
                    rd_d    = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            off_q   <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            off_q   <= off_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated by reset so the core is released as soon as reset asserts.
    assign core_stall_o = rst_i && core_req_i && (state_q != StDone);
    assign core_rd_o    = rd_q;
    assign core_err_o   = (state_q == StDone) && err_q;
    assign mem_req_o    = (state_q == StBusy);
    assign mem_we_o     = we_q;
    assign mem_be_o     = be_q;
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: XLEN=32 (timeout 8) and XLEN=64 instances, directed plan plus random
// transactions checked against an arithmetic reference model.
module tb_riscv_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    bit          cur64;
    logic        c_req, c_we, c_ready;
    logic [2:0]  c_size;
    logic [31:0] c_addr;
    logic [63:0] c_wd, c_rdata;

    int n_run  = 0;
    int n_fail = 0;

    logic        stall32, err32, mreq32, mwe32;
    logic [31:0] rd32, maddr32, mwd32;
    logic [3:0]  be32;
    logic        stall64, err64, mreq64, mwe64;
    logic [63:0] rd64, mwd64;
    logic [31:0] maddr64;
    logic [7:0]  be64;

    riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .core_req_i(c_req && !cur64), .core_we_i(c_we),
        .core_size_i(c_size), .core_addr_i(c_addr), .core_wd_i(c_wd[31:0]),
        .core_stall_o(stall32), .core_rd_o(rd32), .core_err_o(err32), .mem_req_o(mreq32),
        .mem_we_o(mwe32), .mem_be_o(be32), .mem_addr_o(maddr32), .mem_wd_o(mwd32),
        .mem_rd_i(c_rdata[31:0]), .mem_ready_i(c_ready && !cur64)
    );

    riscv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(16)) dut64 (
        .clk_i(clk), .rst_i(rst_n), .core_req_i(c_req && cur64), .core_we_i(c_we),
        .core_size_i(c_size), .core_addr_i(c_addr), .core_wd_i(c_wd),
        .core_stall_o(stall64), .core_rd_o(rd64), .core_err_o(err64), .mem_req_o(mreq64),
        .mem_we_o(mwe64), .mem_be_o(be64), .mem_addr_o(maddr64), .mem_wd_o(mwd64),
        .mem_rd_i(c_rdata), .mem_ready_i(c_ready && cur64)
    );

    logic        o_stall, o_err, o_req, o_we;
    logic [63:0] o_rd, o_wd;
    logic [31:0] o_addr;
    logic [7:0]  o_be;
    assign o_stall = cur64 ? stall64 : stall32;
    assign o_err   = cur64 ? err64 : err32;
    assign o_req   = cur64 ? mreq64 : mreq32;
    assign o_we    = cur64 ? mwe64 : mwe32;
    assign o_rd    = cur64 ? rd64 : {32'b0, rd32};
    assign o_wd    = cur64 ? mwd64 : {32'b0, mwd32};
    assign o_addr  = cur64 ? maddr64 : maddr32;
    assign o_be    = cur64 ? be64 : {4'b0, be32};

    // Reference model: plain byte arithmetic on the architectural rules.
    function automatic bit m_legal(bit x64, logic we, logic [2:0] size, logic [31:0] addr);
        int bytes;
        if (size == 3'd7) return 0;
        if (!x64 && (size == 3'd3 || size == 3'd6)) return 0;
        if (we && size[2]) return 0;
        bytes = 1 << size[1:0];
        return (addr % bytes) == 0;
    endfunction

    function automatic logic [7:0] m_be(bit x64, logic [2:0] size, logic [31:0] addr);
        int bytes, off;
        logic [15:0] m;
        bytes = 1 << size[1:0];
        off   = addr % (x64 ? 8 : 4);
        m     = (16'd1 << bytes) - 16'd1;
        return 8'(m << off);
    endfunction

    function automatic logic [63:0] m_wd(bit x64, logic [2:0] size, logic [63:0] wd);
        int bytes;
        logic [63:0] r;
        bytes = 1 << size[1:0];
        r = '0;
        for (int i = 0; i < (x64 ? 8 : 4); i++) r[8*i +: 8] = wd[8*(i % bytes) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_rd(bit x64, logic we, logic [2:0] size, logic [31:0] addr,
                                         logic [63:0] rdata);
        int bytes, off;
        logic [63:0] mask, v;
        if (we) return 64'd0;
        if (!x64) rdata = rdata & 64'hFFFF_FFFF;
        bytes = 1 << size[1:0];
        off   = addr % (x64 ? 8 : 4);
        mask  = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
        v     = (rdata >> (8 * off)) & mask;
        if (!size[2] && v[8*bytes-1]) v = v | ~mask;
        if (!x64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    // Runs one transaction; ready is raised on BUSY cycle number 'delay' (0 = never).
    task automatic drive(input bit x64, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rdata,
                         input int delay, output int stall_n, output int req_n, output int err_n,
                         output logic [63:0] rd, output logic [7:0] be, output logic [31:0] maddr,
                         output logic [63:0] mwd, output logic mwe, output bit stable,
                         output bit done);
        stall_n = 0; req_n = 0; err_n = 0; rd = '0; be = '0; maddr = '0; mwd = '0; mwe = 1'b0;
        stable = 1; done = 0;
        @(posedge clk); #1;
        cur64 = x64; c_we = we; c_size = size; c_addr = addr; c_wd = wd; c_rdata = rdata;
        c_ready = 1'b0; c_req = 1'b1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (o_req) begin
                req_n++;
                if (req_n == 1) begin
                    be = o_be; maddr = o_addr; mwd = o_wd; mwe = o_we;
                end else if (o_be !== be || o_addr !== maddr || o_wd !== mwd || o_we !== mwe) begin
                    stable = 0;
                end
            end
            if (o_stall) stall_n++;
            if (o_err) err_n++;
            if (!o_stall) begin
                done = 1;
                rd   = o_rd;
            end
            c_ready = o_req && (req_n == delay);
        end
        @(posedge clk); #1;
        c_req = 1'b0; c_ready = 1'b0;
        @(negedge clk);
        if (o_err) err_n++;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; cur64 = 0; c_req = 1'b1; c_we = 0; c_size = 3'd2; c_addr = '0;
        c_wd = '0; c_rdata = '0; c_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_run++; if (o_req !== 1'b0 || o_stall !== 1'b0) begin n_fail++;
            $display("FAIL reset_req_stall: got req=%b stall=%b want 0 0", o_req, o_stall); end
        c_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_run++; if (o_rd !== 64'd0 || o_err !== 1'b0 || o_be !== 8'd0 || o_addr !== 32'd0 ||
                     o_wd !== 64'd0 || o_we !== 1'b0) begin n_fail++;
            $display("FAIL reset_outputs: got rd=%h err=%b be=%h addr=%h wd=%h we=%b want all 0",
                     o_rd, o_err, o_be, o_addr, o_wd, o_we); end
    endtask

    task automatic test_store_word;
        int s, r, e; logic [63:0] rd, mwd; logic [7:0] be; logic [31:0] ma; logic we; bit st, dn;
        drive(0, 1'b1, 3'd2, 32'h100, 64'hDEADBEEF, 64'h0, 2, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (!dn) begin n_fail++; $display("FAIL sw_done: got no DONE want DONE"); end
        n_run++; if (be !== 8'h0F) begin n_fail++; $display("FAIL sw_be: got %h want 0f", be); end
        n_run++; if (ma !== 32'h100) begin n_fail++; $display("FAIL sw_addr: got %h want 100", ma); end
        n_run++; if (mwd !== 64'hDEADBEEF) begin n_fail++;
            $display("FAIL sw_wd: got %h want deadbeef", mwd); end
        n_run++; if (s !== 3 || r !== 2 || e !== 0) begin n_fail++;
            $display("FAIL sw_timing: got stall=%0d req=%0d err=%0d want 3 2 0", s, r, e); end
        n_run++; if (we !== 1'b1 || !st || rd !== 64'd0) begin n_fail++;
            $display("FAIL sw_misc: got we=%b stable=%0d rd=%h want 1 1 0", we, st, rd); end
    endtask

    task automatic test_load_byte;
        int s, r, e; logic [63:0] rd, mwd; logic [7:0] be; logic [31:0] ma; logic we; bit st, dn;
        drive(0, 1'b0, 3'd0, 32'h103, 64'h0, 64'h80FF0011, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (be !== 8'h08 || rd !== 64'hFFFFFF80 || s !== 2 || e !== 0) begin n_fail++;
            $display("FAIL lb: got be=%h rd=%h stall=%0d err=%0d want 08 ffffff80 2 0",
                     be, rd, s, e); end
        n_run++; if (o_rd !== 64'hFFFFFF80) begin n_fail++;
            $display("FAIL lb_hold: got %h want ffffff80", o_rd); end
        drive(0, 1'b0, 3'd4, 32'h103, 64'h0, 64'h80FF0011, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (be !== 8'h08 || rd !== 64'h80 || e !== 0) begin n_fail++;
            $display("FAIL lbu: got be=%h rd=%h err=%0d want 08 80 0", be, rd, e); end
    endtask

    task automatic test_store_half;
        int s, r, e; logic [63:0] rd, mwd; logic [7:0] be; logic [31:0] ma; logic we; bit st, dn;
        drive(0, 1'b1, 3'd1, 32'h102, 64'h1234, 64'h0, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (be !== 8'h0C || mwd !== 64'h12341234 || ma !== 32'h100) begin n_fail++;
            $display("FAIL sh: got be=%h wd=%h addr=%h want 0c 12341234 100", be, mwd, ma); end
    endtask

    task automatic test_illegal;
        int s, r, e; logic [63:0] rd, mwd; logic [7:0] be; logic [31:0] ma; logic we; bit st, dn;
        drive(0, 1'b0, 3'd2, 32'h102, 64'h0, 64'h0, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (r !== 0 || s !== 1 || e !== 1) begin n_fail++;
            $display("FAIL lw_misaligned: got req=%0d stall=%0d err=%0d want 0 1 1", r, s, e); end
        drive(0, 1'b0, 3'd3, 32'h100, 64'h0, 64'h0, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (r !== 0 || s !== 1 || e !== 1) begin n_fail++;
            $display("FAIL ld_on_rv32: got req=%0d stall=%0d err=%0d want 0 1 1", r, s, e); end
        drive(0, 1'b1, 3'd4, 32'h100, 64'h0, 64'h0, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (r !== 0 || s !== 1 || e !== 1) begin n_fail++;
            $display("FAIL store_unsigned: got req=%0d stall=%0d err=%0d want 0 1 1", r, s, e); end
    endtask

    task automatic test_timeout;
        int s, r, e; logic [63:0] rd, mwd; logic [7:0] be; logic [31:0] ma; logic we; bit st, dn;
        drive(0, 1'b0, 3'd2, 32'h100, 64'h0, 64'h55, 0, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (!dn || r !== 8 || s !== 9 || e !== 1 || rd !== 64'd0) begin n_fail++;
            $display("FAIL timeout: got done=%0d req=%0d stall=%0d err=%0d rd=%h want 1 8 9 1 0",
                     dn, r, s, e, rd); end
        drive(0, 1'b0, 3'd2, 32'h104, 64'h0, 64'hCAFEF00D, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (rd !== 64'hCAFEF00D || e !== 0 || s !== 2) begin n_fail++;
            $display("FAIL after_timeout: got rd=%h err=%0d stall=%0d want cafef00d 0 2",
                     rd, e, s); end
    endtask

    task automatic test_reset_mid_busy;
        int s, r, e; logic [63:0] rd, mwd; logic [7:0] be; logic [31:0] ma; logic we; bit st, dn;
        @(posedge clk); #1;
        cur64 = 0; c_we = 1'b0; c_size = 3'd2; c_addr = 32'h200; c_ready = 1'b0; c_req = 1'b1;
        repeat (3) @(negedge clk);
        n_run++; if (o_req !== 1'b1) begin n_fail++;
            $display("FAIL rst_pre_busy: got req=%b want 1", o_req); end
        #1 rst_n = 1'b0;
        #1;
        n_run++; if (o_req !== 1'b0 || o_stall !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_busy: got req=%b stall=%b want 0 0", o_req, o_stall); end
        c_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 1'b0, 3'd2, 32'h0, 64'h0, 64'h12345678, 1, s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (rd !== 64'h12345678 || s !== 2 || e !== 0) begin n_fail++;
            $display("FAIL rst_recover: got rd=%h stall=%0d err=%0d want 12345678 2 0", rd, s, e); end
    endtask

    task automatic test_xlen64;
        int s, r, e; logic [63:0] rd, mwd; logic [7:0] be; logic [31:0] ma; logic we; bit st, dn;
        drive(1, 1'b0, 3'd6, 32'h104, 64'h0, 64'hFFFFFFFF_00000000, 1,
              s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (be !== 8'hF0 || rd !== 64'h00000000_FFFFFFFF || ma !== 32'h100) begin n_fail++;
            $display("FAIL lwu64: got be=%h rd=%h addr=%h want f0 00000000ffffffff 100",
                     be, rd, ma); end
        drive(1, 1'b0, 3'd2, 32'h104, 64'h0, 64'hFFFFFFFF_00000000, 2,
              s, r, e, rd, be, ma, mwd, we, st, dn);
        n_run++; if (rd !== 64'hFFFFFFFF_FFFFFFFF || s !== 3) begin n_fail++;
            $display("FAIL lw64: got rd=%h stall=%0d want ffffffffffffffff 3", rd, s); end
    endtask

    task automatic test_random(input bit x64, input int n);
        int s, r, e, dly; logic [63:0] rd, mwd, wd, rdat; logic [7:0] be; logic [31:0] ma, addr;
        logic we, rwe; logic [2:0] size; bit st, dn;
        for (int i = 0; i < n; i++) begin
            rwe  = 1'($urandom_range(0, 1));
            size = 3'($urandom_range(0, 7));
            addr = 32'h100 + 32'($urandom_range(0, 255));
            wd   = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            dly  = $urandom_range(1, 3);
            drive(x64, rwe, size, addr, wd, rdat, dly, s, r, e, rd, be, ma, mwd, we, st, dn);
            if (m_legal(x64, rwe, size, addr)) begin
                n_run++;
                if (!dn || s !== 1 + dly || r !== dly || e !== 0 || !st || we !== rwe ||
                    be !== m_be(x64, size, addr) || ma !== (addr & ~32'(x64 ? 7 : 3)) ||
                    mwd !== m_wd(x64, size, wd) || rd !== m_rd(x64, rwe, size, addr, rdat)) begin
                    n_fail++;
                    $display("FAIL rand%0d_%0d: we=%b size=%0d addr=%h got be=%h addr=%h wd=%h rd=%h stall=%0d req=%0d err=%0d want be=%h addr=%h wd=%h rd=%h stall=%0d req=%0d err=0",
                             x64 ? 64 : 32, i, rwe, size, addr, be, ma, mwd, rd, s, r, e,
                             m_be(x64, size, addr), addr & ~32'(x64 ? 7 : 3),
                             m_wd(x64, size, wd), m_rd(x64, rwe, size, addr, rdat), 1 + dly, dly);
                end
            end else begin
                n_run++;
                if (!dn || s !== 1 || r !== 0 || e !== 1) begin
                    n_fail++;
                    $display("FAIL rand%0d_%0d_err: we=%b size=%0d addr=%h got stall=%0d req=%0d err=%0d want 1 0 1",
                             x64 ? 64 : 32, i, rwe, size, addr, s, r, e);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half();
        test_illegal();
        test_timeout();
        test_reset_mid_busy();
        test_xlen64();
        test_random(0, 40);
        test_random(1, 40);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
